edgedetector_filt: RTL
======================

# edgedetector_filt

Multi-channel, parametrised successor to the single-stage edge detector. Each of `WIDTH` asynchronous input channels is synchronised, then glitch-filtered by a per-channel stability counter. One-cycle rising/falling pulses are produced on the filtered level, and sticky per-channel event flags feed a single maskable interrupt. The block sits between raw external/async status lines and the control logic that consumes their edges.

## Interface
Parameters:
- `WIDTH`, 1, number of independent channels (>= 1)
- `SYNC_STAGES`, 2, synchroniser flops per channel (>= 2)
- `FILT_CYCLES`, 4, consecutive cycles a new level must hold before it is accepted (>= 1)
- `CNT_W`, derived `$clog2(FILT_CYCLES+1)`, filter counter width; not overridden

Ports:
- `clk`  input  1  single clock; all state on rising edge
- `n_rst`  input  1  asynchronous, active-low reset
- `signal`  input  WIDTH  raw, possibly asynchronous, channel inputs
- `pos_en`  input  WIDTH  per-channel enable for rising-edge flag capture
- `neg_en`  input  WIDTH  per-channel enable for falling-edge flag capture
- `clear`  input  WIDTH  per-channel clear of both sticky flags; sampled each cycle
- `level`  output  WIDTH  filtered, debounced level
- `pos_edge`  output  WIDTH  one-cycle pulse when `level[i]` goes 0->1
- `neg_edge`  output  WIDTH  one-cycle pulse when `level[i]` goes 1->0
- `pos_flag`  output  WIDTH  sticky rising-edge flag
- `neg_flag`  output  WIDTH  sticky falling-edge flag
- `irq`  output  1  OR of all set flags

## Operation
- Per channel: a synchroniser chain of `SYNC_STAGES` flops feeds `sync[i]`, the last stage. `level[i]` is the accepted state. `cnt[i]` is a `CNT_W`-bit counter.
- Filter, evaluated each cycle:
  - If `sync[i] == level[i]`: `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == FILT_CYCLES-1`: `level[i] <= sync[i]`, `cnt[i] <= 0`, and the matching edge register is set for the next cycle.
  - Otherwise: `cnt[i] <= cnt[i]+1`.
  - A pulse on `sync[i]` shorter than `FILT_CYCLES` cycles therefore never changes `level[i]`. Any return to the old level restarts the count from zero.
- Edge pulses:
  - `pos_edge[i]` and `neg_edge[i]` are flops, high for exactly one cycle, in the cycle where `level[i]` first shows its new value.
  - They are never high together.
  - They are not gated by `pos_en`/`neg_en`.
- Sticky flags:
  - `pos_flag[i] <= (pos_flag[i] & ~clear[i]) | (pos_edge[i] & pos_en[i])`; `neg_flag` is symmetric.
  - If set and clear occur in the same cycle, set wins.
  - Disabling an enable does not clear an already-set flag.
- `irq = |(pos_flag | neg_flag)` is a combinational OR of flops, so it is glitch-free.
- Channels are fully independent; there is no cross-channel interaction.

## Timing
- Reset (`n_rst` low, asynchronous, any time including mid-filter): all synchroniser flops, `level`, `cnt`, `pos_edge`, `neg_edge`, `pos_flag` and `neg_flag` go to 0 immediately. `irq` is 0.
- After reset, a channel whose input is already high reports a normal `pos_edge` after full latency, because `level` resets to 0.
- Latency: input stable before rising edge k -> `level[i]`/edge pulse visible after edge k + `SYNC_STAGES` + `FILT_CYCLES` - 1. With defaults this is edge k+5, i.e. 6 edges inclusive.
- Flag visible one cycle after its pulse; `irq` in the same cycle as the flag.
- Clear latency: flag low one cycle after `clear[i]` is sampled high (absent a simultaneous set).
- Minimum accepted input period per level: `FILT_CYCLES` cycles after synchronisation. Back-to-back opposite edges can occur `FILT_CYCLES` cycles apart.
- `FILT_CYCLES = 1`: the filter is a single-cycle accept, `cnt` stays 0, and latency is `SYNC_STAGES` edges.

## Test plan
- Defaults, `WIDTH=4`. `signal[0]` 0->1 before edge 1 and held -> `level[0]` and `pos_edge[0]` high after edge 6; `pos_edge[0]` low after edge 7; `pos_flag[0]`=1 and `irq`=1 after edge 7 with `pos_en[0]=1`. Other channels stay 0.
- Glitch: `signal[1]` high for 3 cycles, then low -> no `pos_edge`/`neg_edge`, `level[1]` stays 0. Same pulse held for 4 cycles -> exactly one `pos_edge[1]`, followed later by one `neg_edge[1]`.
- Flag/clear: `pos_en=0` with an edge -> pulse seen, `pos_flag` stays 0. Then with `pos_en=1`, set `pos_flag[2]` and pulse `clear[2]` in the same cycle as a new `neg_edge[2]` with `neg_en[2]=1` -> `pos_flag[2]`=0 and `neg_flag[2]`=1.
- Simultaneous set/clear: `clear[3]` held high while `pos_edge[3]` fires -> `pos_flag[3]`=1 the next cycle; it drops one cycle after the edge pulse ends.
- Reset mid-filter: `signal[0]` high, assert `n_rst` low when `cnt[0]`=2 -> all outputs 0 immediately. Release with `signal[0]` still high -> `pos_edge[0]` exactly 6 edges after release.
- Parameter sweep: `SYNC_STAGES=3`, `FILT_CYCLES=1`, `WIDTH=1` -> single-cycle input pulse produces `pos_edge` after 3 edges and `neg_edge` one cycle later.

Source files
------------

// File: rtl/edgedetector_filt.sv
// Per-channel synchroniser, stability filter, edge pulses, sticky flags and maskable irq.
// Latency: input to level/edge pulse is SYNC_STAGES+FILT_CYCLES-1 edges after capture; flag +1.
// No backpressure: inputs are sampled every cycle and outputs are never stalled.
module edgedetector_filt #(
  parameter  int WIDTH       = 1,
  parameter  int SYNC_STAGES = 2,
  parameter  int FILT_CYCLES = 4,
  localparam int CNT_W       = $clog2(FILT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] signal,
  input  logic [WIDTH-1:0] pos_en,
  input  logic [WIDTH-1:0] neg_en,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] pos_flag,
  output logic [WIDTH-1:0] neg_flag,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0][CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]                  r_level;
  logic [WIDTH-1:0]                  r_pos_edge;
  logic [WIDTH-1:0]                  r_neg_edge;
  logic [WIDTH-1:0]                  r_pos_flag;
  logic [WIDTH-1:0]                  r_neg_flag;

  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_mismatch;
  logic [WIDTH-1:0]                  w_accept;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_sync ^ r_level;

  // A channel accepts its new level once the mismatch has lasted FILT_CYCLES evaluations.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_mismatch[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  // Synchroniser chain: stage 0 captures the raw input, last stage feeds the filter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= signal;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Stability counter: any return to the accepted level restarts the count from zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_mismatch[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Accepted level and its edge pulses update together, so a pulse coincides with the new level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_level    <= '0;
      r_pos_edge <= '0;
      r_neg_edge <= '0;
    end else begin
      r_level    <= r_level ^ w_accept;
      r_pos_edge <= w_accept & w_sync;
      r_neg_edge <= w_accept & ~w_sync;
    end
  end

  // Sticky flags: an enabled edge sets, clear drops; a coincident set beats the clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pos_flag <= '0;
      r_neg_flag <= '0;
    end else begin
      r_pos_flag <= (r_pos_flag & ~clear) | (r_pos_edge & pos_en);
      r_neg_flag <= (r_neg_flag & ~clear) | (r_neg_edge & neg_en);
    end
  end

  assign level    = r_level;
  assign pos_edge = r_pos_edge;
  assign neg_edge = r_neg_edge;
  assign pos_flag = r_pos_flag;
  assign neg_flag = r_neg_flag;
  // OR of flops only, so the interrupt line cannot glitch.
  assign irq      = |(r_pos_flag | r_neg_flag);

endmodule
